mdu_ctrl: RTL and testbench

Issue and hazard controller for the multicycle multiply/divide unit in the E stage of the MIPS pipeline. It turns decoded MDU-class instructions into one-cycle start and write strobes for the MDU and tracks the MDU's busy window with an internal FSM and countdown. It generates the stall that holds the E stage while a result is pending. On an accepted interrupt/exception it cancels any in-flight operation and drives the HI/LO restore strobe.

---
 rtl/mdu_pkg.sv | 67 ++++++
 rtl/mdu_busy_timer.sv | 27 ++
 rtl/mdu_ctrl.sv | 121 ++++++++++++
 tb/tb_mdu_ctrl.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared encodings for the E-stage multiply/divide issue controller.
package mdu_pkg;

  // Decoded MDU-class instruction kinds as presented by the E stage.
  typedef enum logic [2:0] {
    KIND_MULTU = 3'd0,
    KIND_MULT  = 3'd1,
    KIND_DIVU  = 3'd2,
    KIND_DIV   = 3'd3,
    KIND_MADD  = 3'd4,
    KIND_MTHI  = 3'd5,
    KIND_MTLO  = 3'd6,
    KIND_MFHL  = 3'd7
  } mdu_kind_e;

  // Operation select seen by the MDU datapath.
  typedef enum logic [1:0] {
    OP_MULU = 2'b00,
    OP_MUL  = 2'b01,
    OP_DIVU = 2'b10,
    OP_DIV  = 2'b11
  } mdu_op_e;

  // Controller FSM.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } mdu_state_e;

  // Default busy windows and the countdown width that covers them.
  localparam int MUL_LAT_DEF = 5;
  localparam int DIV_LAT_DEF = 10;
  localparam int CNT_W       = 4;

  // One E-stage request, bundled from the individual ports.
  typedef struct packed {
    logic      valid;
    mdu_kind_e kind;
    logic      div_zero;
    logic      flush;
  } mdu_req_t;

  // Everything the controller drives in one cycle.
  typedef struct packed {
    logic       start;
    logic [1:0] op;
    logic       madd;
    logic       we;
    logic       hilo;
    logic       restore;
    logic       stall;
    logic       busy;
    logic       done;
  } mdu_rsp_t;

  // Kinds that launch a multiply-class operation.
  function automatic logic is_mul(input mdu_kind_e k);
    return (k == KIND_MULTU) || (k == KIND_MULT) || (k == KIND_MADD);
  endfunction

  // Kinds that launch a divide-class operation (before the zero check).
  function automatic logic is_div(input mdu_kind_e k);
    return (k == KIND_DIVU) || (k == KIND_DIV);
  endfunction

endpackage

// File: rtl/mdu_busy_timer.sv
// Loadable down-counter that marks the final cycle of an MDU busy window.
module mdu_busy_timer
  import mdu_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] value,
  input  logic         clear,
  output logic         last
);

  logic [W-1:0] cnt;

  // clear beats load; otherwise count down and rest at zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             cnt <= '0;
    else if (clear)         cnt <= '0;
    else if (load)          cnt <= value;
    else if (cnt != '0)     cnt <= cnt - W'(1);
  end

  assign last = (cnt == W'(1));

endmodule

// File: rtl/mdu_ctrl.sv
// Issue/hazard controller for the multicycle MDU in the E stage.
// Launches MDU operations, stalls E while a result is pending and
// cancels in-flight work with a HI/LO restore when M takes a trap.
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int DIV_LAT = DIV_LAT_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  input  logic [2:0] req_kind,
  input  logic       div_zero,
  input  logic       flush,
  output logic       mdu_start,
  output logic [1:0] mdu_op,
  output logic       mdu_madd,
  output logic       mdu_we,
  output logic       mdu_hilo,
  output logic       mdu_restore,
  output logic       stall,
  output logic       busy,
  output logic       done
);

  mdu_state_e       state_q, state_d;
  mdu_req_t         req;
  mdu_rsp_t         rsp;
  logic             tmr_load, tmr_clr, tmr_last;
  logic [CNT_W-1:0] tmr_val;

  assign req.valid    = req_valid;
  assign req.kind     = mdu_kind_e'(req_kind);
  assign req.div_zero = div_zero;
  assign req.flush    = flush;

  mdu_busy_timer #(.W(CNT_W)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (tmr_load),
    .value (tmr_val),
    .clear (tmr_clr),
    .last  (tmr_last)
  );

  // state register; reset drops any in-flight op without a restore
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // next state, timer control and output decode
  always_comb begin
    state_d  = state_q;
    tmr_load = 1'b0;
    tmr_clr  = 1'b0;
    tmr_val  = '0;
    rsp      = '0;
    rsp.busy = (state_q != ST_IDLE);

    if (req.flush) begin
      // trap in M: kill everything, roll HI/LO back
      rsp.restore = 1'b1;
      state_d     = ST_IDLE;
      tmr_clr     = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req.valid) begin
            if (is_mul(req.kind)) begin
              rsp.start = 1'b1;
              rsp.op    = (req.kind == KIND_MULTU) ? OP_MULU : OP_MUL;
              rsp.madd  = (req.kind == KIND_MADD);
              state_d   = ST_MUL;
              tmr_load  = 1'b1;
              tmr_val   = CNT_W'(MUL_LAT);
            end else if (is_div(req.kind)) begin
              // zero divisor: architecturally undefined, leave HI/LO alone
              if (!req.div_zero) begin
                rsp.start = 1'b1;
                rsp.op    = (req.kind == KIND_DIVU) ? OP_DIVU : OP_DIV;
                state_d   = ST_DIV;
                tmr_load  = 1'b1;
                tmr_val   = CNT_W'(DIV_LAT);
              end
            end else if (req.kind == KIND_MTHI || req.kind == KIND_MTLO) begin
              rsp.we   = 1'b1;
              rsp.hilo = (req.kind == KIND_MTLO);
            end
            // MFHI/MFLO: HI/LO are current in IDLE, nothing to do
          end
        end
        ST_MUL, ST_DIV: begin
          // any MDU-class instruction must wait; it re-presents in IDLE
          rsp.stall = req.valid;
          rsp.done  = tmr_last;
          if (tmr_last) state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
          tmr_clr = 1'b1;
        end
      endcase
    end

    // keep the MDU quiet while the pipeline is held in reset
    if (!rst_n) rsp = '0;
  end

  assign mdu_start   = rsp.start;
  assign mdu_op      = rsp.op;
  assign mdu_madd    = rsp.madd;
  assign mdu_we      = rsp.we;
  assign mdu_hilo    = rsp.hilo;
  assign mdu_restore = rsp.restore;
  assign stall       = rsp.stall;
  assign busy        = rsp.busy;
  assign done        = rsp.done;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl: each driven cycle queues its expected
// output vector, a negedge monitor pops and compares.
module tb_mdu_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid;
  logic [2:0] req_kind;
  logic       div_zero;
  logic       flush;
  logic       mdu_start;
  logic [1:0] mdu_op;
  logic       mdu_madd;
  logic       mdu_we;
  logic       mdu_hilo;
  logic       mdu_restore;
  logic       stall;
  logic       busy;
  logic       done;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string      nm;
    logic [9:0] v;
  } exp_t;

  exp_t q[$];

  // vector: {start, op[1:0], madd, we, hilo, restore, stall, busy, done}
  localparam logic [9:0] E0     = 10'b0_00_0_0_0_0_0_0_0;
  localparam logic [9:0] EB     = 10'b0_00_0_0_0_0_0_1_0;
  localparam logic [9:0] EBD    = 10'b0_00_0_0_0_0_0_1_1;
  localparam logic [9:0] EBS    = 10'b0_00_0_0_0_0_1_1_0;
  localparam logic [9:0] EBSD   = 10'b0_00_0_0_0_0_1_1_1;
  localparam logic [9:0] ER     = 10'b0_00_0_0_0_1_0_0_0;
  localparam logic [9:0] EBR    = 10'b0_00_0_0_0_1_0_1_0;
  localparam logic [9:0] EMULTU = 10'b1_00_0_0_0_0_0_0_0;
  localparam logic [9:0] EMULT  = 10'b1_01_0_0_0_0_0_0_0;
  localparam logic [9:0] EMADD  = 10'b1_01_1_0_0_0_0_0_0;
  localparam logic [9:0] EDIVU  = 10'b1_10_0_0_0_0_0_0_0;
  localparam logic [9:0] EDIV   = 10'b1_11_0_0_0_0_0_0_0;
  localparam logic [9:0] EMTHI  = 10'b0_00_0_1_0_0_0_0_0;
  localparam logic [9:0] EMTLO  = 10'b0_00_0_1_1_0_0_0_0;

  mdu_ctrl #(.MUL_LAT(5), .DIV_LAT(10)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_kind    (req_kind),
    .div_zero    (div_zero),
    .flush       (flush),
    .mdu_start   (mdu_start),
    .mdu_op      (mdu_op),
    .mdu_madd    (mdu_madd),
    .mdu_we      (mdu_we),
    .mdu_hilo    (mdu_hilo),
    .mdu_restore (mdu_restore),
    .stall       (stall),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  // monitor: compare the current cycle's outputs against the queued vector
  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t e;
      logic [9:0] act;
      e   = q.pop_front();
      act = {mdu_start, mdu_op, mdu_madd, mdu_we, mdu_hilo, mdu_restore, stall, busy, done};
      checks++;
      if (act !== e.v) begin
        errors++;
        $display("FAIL %s: got %b want %b (start op madd we hilo restore stall busy done)",
                 e.nm, act, e.v);
      end
    end
  end

  task automatic step(input logic rn, input logic v, input logic [2:0] k,
                      input logic dz, input logic fl, input logic [9:0] e,
                      input string nm);
    @(posedge clk);
    #1;
    rst_n = rn; req_valid = v; req_kind = k; div_zero = dz; flush = fl;
    q.push_back('{nm, e});
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b1; req_kind = 3'd1; div_zero = 1'b0; flush = 1'b1;

    // reset: outputs silent even with a request and flush present
    step(0, 1, 3'd1, 0, 1, E0, "reset_quiet");
    step(0, 1, 3'd1, 0, 0, E0, "reset_quiet2");

    // MULT issued in the first cycle after release
    step(1, 1, 3'd1, 0, 0, EMULT, "mult_issue");
    for (int i = 0; i < 4; i++) step(1, 0, 3'd0, 0, 0, EB, "mult_busy");
    step(1, 0, 3'd0, 0, 0, EBD, "mult_done");
    step(1, 0, 3'd0, 0, 0, E0, "mult_idle");

    // DIV with MFHI held behind it
    step(1, 1, 3'd3, 0, 0, EDIV, "div_issue");
    for (int i = 0; i < 9; i++) step(1, 1, 3'd7, 0, 0, EBS, "div_stall");
    step(1, 1, 3'd7, 0, 0, EBSD, "div_stall_done");
    step(1, 1, 3'd7, 0, 0, E0, "mfhi_idle");

    // MADD with a MULTU held, issuing right after done
    step(1, 1, 3'd4, 0, 0, EMADD, "madd_issue");
    for (int i = 0; i < 4; i++) step(1, 1, 3'd0, 0, 0, EBS, "madd_stall");
    step(1, 1, 3'd0, 0, 0, EBSD, "madd_done");
    step(1, 1, 3'd0, 0, 0, EMULTU, "b2b_multu");
    for (int i = 0; i < 4; i++) step(1, 0, 3'd0, 0, 0, EB, "multu_busy");
    step(1, 0, 3'd0, 0, 0, EBD, "multu_done");

    // divide by zero is a no-op, then MTLO / MTHI / DIVU by zero
    step(1, 1, 3'd3, 1, 0, E0, "div0_nostart");
    step(1, 1, 3'd6, 0, 0, EMTLO, "mtlo");
    step(1, 1, 3'd5, 0, 0, EMTHI, "mthi");
    step(1, 1, 3'd2, 1, 0, E0, "divu0_nostart");

    // flush mid-divide (with a request present), then MULTU issues freely
    step(1, 1, 3'd2, 0, 0, EDIVU, "divu_issue");
    for (int i = 0; i < 3; i++) step(1, 0, 3'd0, 0, 0, EB, "divu_busy");
    step(1, 1, 3'd7, 0, 1, EBR, "divu_flush");
    step(1, 1, 3'd0, 0, 0, EMULTU, "post_flush_multu");
    for (int i = 0; i < 4; i++) step(1, 0, 3'd0, 0, 0, EB, "multu2_busy");
    // flush in the done cycle: no done, restore instead
    step(1, 0, 3'd0, 0, 1, EBR, "flush_on_done");
    step(1, 0, 3'd0, 0, 0, E0, "after_flush_idle");

    // flush collides with an issue in IDLE
    step(1, 1, 3'd1, 0, 1, ER, "flush_vs_issue");
    step(1, 0, 3'd0, 0, 0, E0, "collision_idle");

    // asynchronous reset mid-MULT
    step(1, 1, 3'd1, 0, 0, EMULT, "mult2_issue");
    step(1, 0, 3'd0, 0, 0, EB, "mult2_busy");
    step(0, 0, 3'd0, 0, 0, E0, "rst_mid_op");
    step(0, 1, 3'd1, 0, 0, E0, "rst_held");
    step(1, 0, 3'd0, 0, 0, E0, "rst_release_idle");
    step(1, 1, 3'd5, 0, 0, EMTHI, "post_rst_mthi");
    step(1, 0, 3'd0, 0, 0, E0, "final_idle");

    // let the monitor drain, bounded
    for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d entries left, want 0", q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
